// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Fixed-latency word array with stall/ready handshake.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req;
  logic          commit;
  logic          misal;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign misal       = addr_i[1:0] != 2'b00;
  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^addr_i[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything happens on the edge entering DONE; inputs are sampled only there.
  always_comb begin
    wr_en   = commit & MemWrite_i & ~misal;
    data_d  = data_q;
    if (commit & MemRead_i & ~MemWrite_i & ~misal) begin
      data_d = mem_q[idx];
    end
    ready_d = commit;
    err_d   = commit & ((MemRead_i & MemWrite_i) | (req & misal));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; a reset asserted at the commit edge blocks the write.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[idx] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;
  assign stall_o = req & (state_q != DONE);

endmodule
